// File: rtl/fifo_drain_ctrl.sv
// Drains a one-cycle-latency FIFO into a valid/ready stream through a small
// FIFO-ordered skid buffer, with a run/stop controller and status counters.
module fifo_drain_ctrl #(
    parameter int FIFO_WIDTH = 16,
    parameter int SKID_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [15:0]           word_cnt,
    output logic                  underflow_err,
    output logic                  busy
);

    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SKID_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_L  = (CNT_W + 1)'(SKID_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    state_t                r_state;
    logic                  r_pend;
    logic [FIFO_WIDTH-1:0] r_mem [SKID_DEPTH];
    logic [PTR_W-1:0]      r_rdPtr;
    logic [PTR_W-1:0]      r_wrPtr;
    logic [CNT_W-1:0]      r_count;
    logic [15:0]           r_wordCnt;
    logic                  r_underflowErr;

    logic                  w_rdEn;
    logic                  w_capture;
    logic                  w_accept;
    logic                  w_valid;
    logic [CNT_W:0]        w_occupancy;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Reads are throttled on buffered plus in-flight words so a capture never overflows.
    assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_pend};
    assign w_rdEn      = !rst && (r_state == RUN) && en && !fifo_empty && (w_occupancy < DEPTH_L);
    assign w_capture   = r_pend;
    assign w_valid     = !rst && (r_count != '0);
    assign w_accept    = w_valid && m_ready;

    assign fifo_rd_en    = w_rdEn;
    assign m_valid       = w_valid;
    assign m_data        = w_valid ? r_mem[r_rdPtr] : '0;
    assign word_cnt      = r_wordCnt;
    assign underflow_err = r_underflowErr;
    assign busy          = !rst && (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: if (en) r_state <= RUN;
                RUN:  if (!en) r_state <= STOP;
                STOP: begin
                    if (en)
                        r_state <= RUN;
                    else if (!r_pend && (r_count == '0))
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture && !rst)
            r_mem[r_wrPtr] <= fifo_data_out;
    end

    // Simultaneous capture and pop leave the count unchanged; pointers keep order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend  <= 1'b0;
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            r_pend <= w_rdEn;
            if (w_capture)
                r_wrPtr <= nextPtr(r_wrPtr);
            if (w_accept)
                r_rdPtr <= nextPtr(r_rdPtr);
            case ({w_capture, w_accept})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wordCnt      <= '0;
            r_underflowErr <= 1'b0;
        end else begin
            if (w_accept)
                r_wordCnt <= r_wordCnt + 16'd1;
            if (fifo_underflow)
                r_underflowErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl: a behavioural one-cycle-latency FIFO
// feeds the DUT and a scoreboard queue checks every accepted word in order.
module tb_fifo_drain_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        fifo_empty;
    logic [15:0] fifo_data_out;
    logic        fifo_underflow;
    logic        fifo_rd_en;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready;
    logic [15:0] word_cnt;
    logic        underflow_err;
    logic        busy;

    logic [15:0] mem [256];
    int          wrIdx = 0;
    int          rdIdx = 0;

    logic [15:0] expQ [$];
    logic [15:0] expWord;
    logic [15:0] modelCnt;
    int          compareCnt = 0;
    int          failCnt = 0;
    int          tickNum = 0;
    int          acceptTotal = 0;
    int          rdPulses = 0;
    int          validTicks = 0;
    int          rdWhileEmpty = 0;
    int          baseTick;
    int          firstAccept;
    int          lastAccept;
    int          beforeCnt;
    int          thisTick;

    fifo_drain_ctrl #(.FIFO_WIDTH(16), .SKID_DEPTH(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_underflow(fifo_underflow),
        .fifo_rd_en    (fifo_rd_en),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .word_cnt      (word_cnt),
        .underflow_err (underflow_err),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Source FIFO model: data appears on fifo_data_out the cycle after a read.
    assign fifo_empty = (rdIdx == wrIdx);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data_out <= mem[rdIdx % 256];
            rdIdx         <= rdIdx + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCnt++;
        assert (observed === expected)
        else begin
            failCnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstV, input logic enV, input logic readyV, input logic underflowV);
        rst            = rstV;
        en             = enV;
        m_ready        = readyV;
        fifo_underflow = underflowV;
    endtask

    task automatic loadWord(input logic [15:0] w);
        mem[wrIdx % 256] = w;
        wrIdx            = wrIdx + 1;
        expQ.push_back(w);
    endtask

    // One clock: sample mid-cycle, score any accepted word, advance to the next falling edge.
    task automatic tick();
        logic rstNow;
        logic accepted;
        #1;
        rstNow   = rst;
        accepted = 1'b0;
        if (fifo_rd_en) rdPulses++;
        if (fifo_rd_en && fifo_empty) rdWhileEmpty++;
        if (m_valid) validTicks++;
        if (!rstNow && m_valid && m_ready) begin
            accepted = 1'b1;
            if (expQ.size() == 0) begin
                checkOutput("sb_extra_word", 32'(m_valid), 32'd0);
            end else begin
                expWord = expQ.pop_front();
                checkOutput("sb_data", 32'(m_data), 32'(expWord));
            end
            modelCnt    = modelCnt + 16'd1;
            acceptTotal++;
        end
        tickNum++;
        @(negedge clk);
        if (rstNow) modelCnt = '0;
        if (accepted) checkOutput("word_cnt", 32'(word_cnt), 32'(modelCnt));
    endtask

    initial begin
        modelCnt = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_m_data", 32'(m_data), 32'd0);
        checkOutput("rst_word_cnt", 32'(word_cnt), 32'd0);
        checkOutput("rst_underflow", 32'(underflow_err), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_m_valid", 32'(m_valid), 32'd0);

        // Stream: eight words back to back once the pipeline fills.
        for (int i = 1; i <= 8; i++) loadWord(16'(i));
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        baseTick    = tickNum;
        firstAccept = -1;
        lastAccept  = -1;
        for (int i = 0; i < 30 && expQ.size() > 0; i++) begin
            beforeCnt = acceptTotal;
            thisTick  = tickNum - baseTick;
            tick();
            if (acceptTotal != beforeCnt) begin
                if (firstAccept < 0) firstAccept = thisTick;
                lastAccept = thisTick;
            end
        end
        checkOutput("stream_drained", 32'(expQ.size()), 32'd0);
        checkOutput("stream_first_cycle", 32'(firstAccept), 32'd3);
        checkOutput("stream_span", 32'(lastAccept - firstAccept), 32'd7);
        checkOutput("stream_word_cnt", 32'(word_cnt), 32'd8);
        checkOutput("stream_m_valid_end", 32'(m_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        checkOutput("stream_idle_busy", 32'(busy), 32'd0);

        // Backpressure: only three reads may be outstanding while the sink stalls.
        for (int i = 0; i < 6; i++) loadWord(16'h0100 + 16'(i));
        rdPulses = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 4) checkOutput("bp_hold_early", 32'(m_data), 32'h0100);
        end
        checkOutput("bp_reads", 32'(rdPulses), 32'd3);
        checkOutput("bp_m_valid", 32'(m_valid), 32'd1);
        checkOutput("bp_hold_late", 32'(m_data), 32'h0100);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 30 && expQ.size() > 0; i++) tick();
        checkOutput("bp_drained", 32'(expQ.size()), 32'd0);
        checkOutput("bp_word_cnt", 32'(word_cnt), 32'd14);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        checkOutput("bp_idle_busy", 32'(busy), 32'd0);

        // Empty boundary: a single word yields one read and one valid beat.
        rdPulses     = 0;
        validTicks   = 0;
        rdWhileEmpty = 0;
        loadWord(16'h00AA);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (8) tick();
        checkOutput("empty_reads", 32'(rdPulses), 32'd1);
        checkOutput("empty_valid_beats", 32'(validTicks), 32'd1);
        checkOutput("empty_m_valid_end", 32'(m_valid), 32'd0);
        checkOutput("empty_rd_when_empty", 32'(rdWhileEmpty), 32'd0);
        checkOutput("empty_underflow", 32'(underflow_err), 32'd0);

        // Stop/restart: drop en right after a read; the in-flight word still arrives.
        loadWord(16'h00B1);
        loadWord(16'h00B2);
        loadWord(16'h00B3);
        rdPulses = 0;
        tick();
        checkOutput("stop_first_read", 32'(rdPulses), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("stop_busy", 32'(busy), 32'd1);
        repeat (3) tick();
        checkOutput("stop_idle_busy", 32'(busy), 32'd0);
        checkOutput("stop_reads", 32'(rdPulses), 32'd1);
        checkOutput("stop_left", 32'(expQ.size()), 32'd2);
        checkOutput("stop_m_valid", 32'(m_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20 && expQ.size() > 0; i++) tick();
        checkOutput("restart_drained", 32'(expQ.size()), 32'd0);

        // Reset mid-stream with two words buffered and one in flight.
        loadWord(16'h00C1);
        loadWord(16'h00C2);
        loadWord(16'h00C3);
        loadWord(16'h00C4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("mid_m_valid", 32'(m_valid), 32'd1);
        checkOutput("mid_m_data", 32'(m_data), 32'h00C1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        wrIdx = rdIdx;
        expQ.delete();
        checkOutput("mrst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("mrst_word_cnt", 32'(word_cnt), 32'd0);
        checkOutput("mrst_busy", 32'(busy), 32'd0);
        checkOutput("mrst_m_data", 32'(m_data), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("post_rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        repeat (2) tick();
        checkOutput("post_rst_no_stale", 32'(m_valid), 32'd0);

        // Sticky underflow flag, cleared only by reset.
        checkOutput("uf_clear", 32'(underflow_err), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("uf_set", 32'(underflow_err), 32'd1);
        repeat (3) tick();
        checkOutput("uf_sticky", 32'(underflow_err), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("uf_rst", 32'(underflow_err), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Counter wrap: preset to 16'hFFFF, then two accepts give 0 then 1.
        force dut.r_wordCnt = 16'hFFFF;
        #1;
        release dut.r_wordCnt;
        modelCnt = 16'hFFFF;
        checkOutput("wrap_preset", 32'(word_cnt), 32'h0000FFFF);
        loadWord(16'h00D1);
        loadWord(16'h00D2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20 && expQ.size() > 0; i++) tick();
        checkOutput("wrap_drained", 32'(expQ.size()), 32'd0);
        checkOutput("wrap_final", 32'(word_cnt), 32'h00000001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, failCnt);
        $finish;
    end

endmodule
